mem_copy_engine: RTL

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies word_count 32-bit words from src_addr to dst_addr, one word at a time, in ascending order.
// Latency: 2N+1 cycles from the first non-IDLE cycle to DONE inclusive (3N+1 with COPY_VERIFY_EN); a count of 0 goes straight to DONE.
// Backpressure: none; the memory answers reads in the same cycle, and start is ignored while busy.
// Optional feature macro: COPY_VERIFY_EN adds a read-back VERIFY state after each write and a sticky error flag.
module mem_copy_engine #(
  parameter int RAM_SIZE_BIT = 8,
  parameter int CNT_W        = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      Address,
  output logic [31:0]      Write_data,
  output logic             MemRead,
  output logic             MemWrite,
  input  logic [31:0]      Mem_data
);

  // Number of words the attached memory decodes; a copy longer than this would lap itself.
  localparam int unsigned MEM_WORDS = 32'd1 << RAM_SIZE_BIT;

`ifdef COPY_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WRITE  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd4
  } state_t;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      data_q;
  logic             armed_q;
  logic             accept;
  logic             step;
  logic             last_word;

  // A start is taken only in IDLE and only once an edge has passed since reset release.
  assign accept    = (state_q == S_IDLE) && start && armed_q;
  assign last_word = (cnt_q == CNT_W'(1));

`ifdef COPY_VERIFY_EN
  // Addresses advance only after the written word has been read back.
  assign step = (state_q == S_VERIFY);
`else
  assign step = (state_q == S_WRITE);
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arms start acceptance one edge after reset deassertion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  // Copy context: word-aligned addresses, remaining count and the word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      if (accept) begin
        src_q <= src_addr & ~32'h3;
        dst_q <= dst_addr & ~32'h3;
        cnt_q <= word_count;
      end else if (step) begin
        // Plain 32-bit arithmetic: addresses wrap modulo 2^32 and the memory wraps on its own decode.
        src_q <= src_q + 32'd4;
        dst_q <= dst_q + 32'd4;
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_q == S_READ) begin
        data_q <= Mem_data;
      end
    end
  end

`ifdef COPY_VERIFY_EN
  logic error_q;

  // Sticky read-back mismatch flag, cleared only by the next accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else if (accept) begin
      error_q <= 1'b0;
    end else if ((state_q == S_VERIFY) && (Mem_data != data_q)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Next-state and memory-bus decode; the bus is idle (all zero) in IDLE and DONE.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    done       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = 32'd0;
    Write_data = 32'd0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) begin
          state_d = (word_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        MemRead = 1'b1;
        Address = src_q;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        MemWrite   = 1'b1;
        Address    = dst_q;
        Write_data = data_q;
`ifdef COPY_VERIFY_EN
        state_d = S_VERIFY;
`else
        state_d = last_word ? S_DONE : S_READ;
`endif
      end
`ifdef COPY_VERIFY_EN
      S_VERIFY: begin
        MemRead = 1'b1;
        Address = dst_q;
        state_d = last_word ? S_DONE : S_READ;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // The memory port is single-ported: reading and writing together would be a bus conflict.
  a_bus_exclusive: assert property (@(posedge clk) disable iff (!reset) !(MemRead && MemWrite));

  // A copy longer than the memory would overwrite its own source words.
  a_count_fits: assert property (@(posedge clk) disable iff (!reset)
                                 accept |-> (32'(word_count) <= MEM_WORDS));

endmodule
